// File: rtl/riscv_hpc_dump.sv
// riscv_hpc_dump: snapshots the HPC counter bus on request and streams it
// out as a framed word sequence (header, counters, XOR trailer) over valid/ready.
module riscv_hpc_dump #(
  parameter int unsigned NUM_CNT = 8,
  parameter logic [15:0] MAGIC   = 16'hC0DE
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic [NUM_CNT*32-1:0]  cnt_bus,
  input  logic                   dump_req,
  output logic                   busy,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   dump_done,
  output logic                   dump_ignored
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEQ_W  = 8;
  localparam int unsigned IDX_W  = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    TRL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  snap_q [NUM_CNT];
  logic [WORD_W-1:0]  xor_q, xor_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               capture;
  logic [WORD_W-1:0]  header;

  logic               busy_d;
  logic               valid_d;
  logic               last_d;
  logic               done_d;
  logic               ign_d;
  logic [WORD_W-1:0]  data_d;

  assign header = {MAGIC, seq_q, 8'(NUM_CNT)};

  // Next-state and next-output logic; outputs are computed for the state being entered
  always_comb begin
    state_d = state_q;
    xor_d   = xor_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    capture = 1'b0;
    data_d  = '0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    ign_d   = dump_req && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (dump_req) begin
          capture = 1'b1;
          xor_d   = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (out_ready) begin
          xor_d   = header;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (out_ready) begin
          xor_d = xor_q ^ snap_q[idx_q];
          if (idx_q == IDX_LAST) begin
            state_d = TRL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      TRL: begin
        if (out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
          seq_d   = seq_q + SEQ_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      HDR:     data_d = header;
      DATA:    data_d = snap_q[idx_d];
      TRL: begin
        data_d = xor_d;
        last_d = 1'b1;
      end
      default: data_d = '0;
    endcase

    valid_d = (state_d != IDLE);
    busy_d  = valid_d;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      xor_q        <= '0;
      idx_q        <= '0;
      seq_q        <= '0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      dump_done    <= 1'b0;
      dump_ignored <= 1'b0;
    end else begin
      state_q      <= state_d;
      xor_q        <= xor_d;
      idx_q        <= idx_d;
      seq_q        <= seq_d;
      busy         <= busy_d;
      out_valid    <= valid_d;
      out_last     <= last_d;
      out_data     <= data_d;
      dump_done    <= done_d;
      dump_ignored <= ign_d;
    end
  end

  // Counter snapshot, frozen for the whole frame
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(NUM_CNT); i++) snap_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < int'(NUM_CNT); i++) snap_q[i] <= cnt_bus[WORD_W*i +: WORD_W];
    end
  end

endmodule
